// File: rtl/arbitro_rr_vc.sv
// Round-robin scheduler that drains four virtual-channel FIFOs into a single
// downstream FIFO. Each grant lasts for a bounded burst, and the scheduler honours almost-full backpressure.
module arbitro_rr_vc #(
  parameter int DATA_W    = 6,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                active_in,
  input  logic [3:0]          fifo_empty,
  input  logic [4*DATA_W-1:0] fifo_data,
  input  logic                dest_afull,
  output logic [3:0]          pop,
  output logic                push,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_grant;
  logic [1:0]        r_last;
  logic [3:0]        r_burst_cnt;
  logic              r_push;
  logic [DATA_W-1:0] r_out_data;

  logic              w_req_any;
  logic [1:0]        w_next_vc;
  logic              w_pop_en;
  logic              w_burst_done;

  // Scan last+4 down to last+1 so that the VC nearest after the last grant is assigned last and wins.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    w_req_any = ~&fifo_empty;
    w_next_vc = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (!fifo_empty[r_last + 2'(k)]) w_next_vc = r_last + 2'(k);
    end
  end

  // The pop is combinational because fifo_empty already accounts for every earlier pop.
  // This lets the scheduler pop on back-to-back cycles without ever popping an empty FIFO.
  assign w_pop_en     = (r_state == GRANT) && active_in && !dest_afull && !fifo_empty[r_grant];
  assign w_burst_done = w_pop_en && (r_burst_cnt == 4'(BURST_MAX - 1));

  always_comb begin
    pop          = '0;
    pop[r_grant] = w_pop_en;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= 2'd0;
      r_last      <= 2'd3;
      r_burst_cnt <= 4'd0;
      r_push      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_push <= w_pop_en;
      if (w_pop_en) r_out_data <= fifo_data[r_grant*DATA_W +: DATA_W];

      case (r_state)
        IDLE: begin
          if (active_in && w_req_any) begin
            r_grant     <= w_next_vc;
            r_burst_cnt <= 4'd0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_pop_en) r_burst_cnt <= r_burst_cnt + 4'd1;
          // Ending the burst takes priority over backpressure.
          if (!active_in || fifo_empty[r_grant] || w_burst_done) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end else if (dest_afull) begin
            r_state <= PAUSE;
          end
        end
        PAUSE: begin
          if (!active_in) begin
            r_last  <= r_grant;
            r_state <= IDLE;
          end else if (!dest_afull) begin
            r_state <= GRANT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign push     = r_push;
  assign out_data = r_out_data;
  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_arbitro_rr_vc.sv
// Directed bench for arbitro_rr_vc: behavioural VC FIFOs, a pop/push monitor,
// and hand-written grant and data sequences for each scenario.
module tb_arbitro_rr_vc;
  localparam int DATA_W    = 6;
  localparam int BURST_MAX = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                active_in;
  logic [3:0]          fifo_empty;
  logic [4*DATA_W-1:0] fifo_data;
  logic                dest_afull;
  logic [3:0]          pop;
  logic                push;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          grant_id;
  logic                busy;

  arbitro_rr_vc #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .active_in  (active_in),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .dest_afull (dest_afull),
    .pop        (pop),
    .push       (push),
    .out_data   (out_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO storage: the main process writes it, and pops are applied just after each rising edge.
  logic [DATA_W-1:0] mem [4][16];
  int                head [4];
  int                cnt  [4];

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]                  = (cnt[i] == 0);
      fifo_data[i*DATA_W +: DATA_W]  = mem[i][head[i] % 16];
    end
  end

  // Monitor records pops and pushes and counts protocol violations.
  logic [3:0]        pop_q;
  logic              prev_pop;
  logic [DATA_W-1:0] exp_q[$];
  int                pop_log[$];
  int                pop_cyc[$];
  int                push_data[$];
  int                mon_err = 0;
  int                cyc_n   = 0;

  always @(negedge clk) begin
    cyc_n++;
    if (!reset) begin
      pop_q    = '0;
      prev_pop = 1'b0;
      exp_q.delete();
    end else begin
      if (push !== prev_pop) mon_err++;
      if (push) begin
        push_data.push_back(int'(out_data));
        if (exp_q.size() == 0 || out_data !== exp_q[0]) mon_err++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if ($isunknown(pop)) mon_err++;
      if (pop != 4'd0) begin
        if (!$onehot(pop) || (pop & fifo_empty) != 4'd0) mon_err++;
        for (int i = 0; i < 4; i++) begin
          if (pop[i]) begin
            pop_log.push_back(i);
            pop_cyc.push_back(cyc_n);
            exp_q.push_back(mem[i][head[i] % 16]);
          end
        end
      end
      pop_q    = pop;
      prev_pop = |pop;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_vc[$];
  int exp_dat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_q[i] && cnt[i] > 0) begin
        head[i]++;
        cnt[i]--;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int vc, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[vc][(head[vc] + cnt[vc]) % 16] = DATA_W'(base + k);
      cnt[vc]++;
    end
  endtask

  task automatic wait_quiet(input string tag, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      cyc();
      sample();
      if (fifo_empty == 4'hF && !busy && !push) done = 1'b1;
    end
    check({tag, "_drained"}, done, 1);
  endtask

  task automatic wait_pops(input string tag, input int base, input int n);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      cyc();
      sample();
      if (pop_log.size() - base >= n) found = 1'b1;
    end
    check({tag, "_pops_seen"}, found, 1);
  endtask

  task automatic cmp_logs(input string tag, input int bpop, input int bpush);
    int bad_vc;
    int bad_dat;
    bad_vc  = 0;
    bad_dat = 0;
    check({tag, "_pop_cnt"},  pop_log.size() - bpop,    exp_vc.size());
    check({tag, "_push_cnt"}, push_data.size() - bpush, exp_dat.size());
    for (int i = 0; i < exp_vc.size(); i++)
      if (bpop + i >= pop_log.size() || pop_log[bpop + i] != exp_vc[i]) bad_vc++;
    for (int i = 0; i < exp_dat.size(); i++)
      if (bpush + i >= push_data.size() || push_data[bpush + i] != exp_dat[i]) bad_dat++;
    check({tag, "_grant_seq"}, bad_vc, 0);
    check({tag, "_data_seq"},  bad_dat, 0);
  endtask

  int       bpop, bpush, err0, pq0, ps0;
  int       k_rd [4];
  logic     win_pop, win_busy;

  initial begin
    reset      = 1'b0;
    active_in  = 1'b0;
    dest_afull = 1'b0;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
      k_rd[i] = 0;
      for (int j = 0; j < 16; j++) mem[i][j] = '0;
    end

    // Reset held for two cycles, then released with all FIFOs empty.
    repeat (2) cyc();
    sample();
    check("rst_pop",      pop,      0);
    check("rst_push",     push,     0);
    check("rst_busy",     busy,     0);
    check("rst_grant",    grant_id, 0);
    check("rst_out_data", out_data, 0);
    cyc();
    reset     = 1'b1;
    active_in = 1'b1;
    win_pop  = 1'b0;
    win_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      win_pop  = win_pop | (|pop) | push;
      win_busy = win_busy | busy;
      cyc();
    end
    check("t1_no_traffic", win_pop,  0);
    check("t1_not_busy",   win_busy, 0);

    // All four VCs hold six words each: full bursts, then the two-word remainders.
    bpop  = pop_log.size();
    bpush = push_data.size();
    err0  = mon_err;
    for (int v = 0; v < 4; v++) load(v, 6, v * 16);
    wait_quiet("t2", 200);
    exp_vc.delete();
    exp_dat.delete();
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < ((b < 4) ? 4 : 2); j++) begin
        exp_vc.push_back(b % 4);
        exp_dat.push_back((b % 4) * 16 + k_rd[b % 4]);
        k_rd[b % 4]++;
      end
    end
    cmp_logs("t2", bpop, bpush);
    check("t2_monitor", mon_err - err0, 0);

    // Single requester VC2 with three words.
    bpop  = pop_log.size();
    bpush = push_data.size();
    err0  = mon_err;
    load(2, 3, 40);
    wait_quiet("t3", 50);
    exp_vc  = '{2, 2, 2};
    exp_dat = '{40, 41, 42};
    cmp_logs("t3", bpop, bpush);
    if (pop_cyc.size() >= bpop + 3) check("t3_back_to_back", pop_cyc[bpop + 2] - pop_cyc[bpop], 2);
    else check("t3_back_to_back", pop_cyc.size() - bpop, 3);
    check("t3_grant_held", grant_id, 2);
    check("t3_monitor", mon_err - err0, 0);

    // VC1 bursting, with backpressure for five cycles after the second pop.
    bpop  = pop_log.size();
    bpush = push_data.size();
    err0  = mon_err;
    load(1, 6, 8);
    wait_pops("t4", bpop, 2);
    cyc();
    dest_afull = 1'b1;
    pq0      = pop_log.size();
    ps0      = push_data.size();
    win_pop  = 1'b0;
    win_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      win_pop  = win_pop | (|pop);
      win_busy = win_busy & busy;
      if (c < 4) cyc();
    end
    check("t4_pause_no_pop",   win_pop, 0);
    check("t4_pause_busy",     win_busy, 1);
    check("t4_trailing_push",  push_data.size() - ps0, 1);
    check("t4_pause_pop_cnt",  pop_log.size() - pq0, 0);
    cyc();
    dest_afull = 1'b0;
    wait_quiet("t4", 50);
    exp_vc  = '{1, 1, 1, 1, 1, 1};
    exp_dat = '{8, 9, 10, 11, 12, 13};
    cmp_logs("t4", bpop, bpush);
    if (pop_cyc.size() >= bpop + 6) begin
      check("t4_resume_gap",  pop_cyc[bpop + 2] - pop_cyc[bpop + 1], 7);
      check("t4_resume_pair", pop_cyc[bpop + 3] - pop_cyc[bpop + 2], 1);
      check("t4_regrant_gap", pop_cyc[bpop + 4] - pop_cyc[bpop + 3], 2);
    end else begin
      check("t4_pop_timing", pop_cyc.size() - bpop, 6);
    end
    check("t4_monitor", mon_err - err0, 0);

    // Dropping active_in after VC3's first pop stops popping; VC0 is granted next.
    bpop  = pop_log.size();
    bpush = push_data.size();
    err0  = mon_err;
    load(3, 4, 50);
    load(0, 2, 20);
    wait_pops("t5", bpop, 1);
    cyc();
    active_in = 1'b0;
    pq0     = pop_log.size();
    ps0     = push_data.size();
    win_pop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      win_pop = win_pop | (|pop);
      if (c < 2) cyc();
    end
    check("t5_inactive_no_pop", win_pop, 0);
    check("t5_inflight_push",   push_data.size() - ps0, 1);
    check("t5_idle",            busy, 0);
    check("t5_pop_cnt_off",     pop_log.size() - pq0, 0);
    cyc();
    active_in = 1'b1;
    wait_quiet("t5", 80);
    exp_vc  = '{3, 0, 0, 3, 3, 3};
    exp_dat = '{50, 20, 21, 51, 52, 53};
    cmp_logs("t5", bpop, bpush);
    check("t5_monitor", mon_err - err0, 0);

    // Reset asserted mid-burst, while a push is in flight and a pop is active.
    bpop  = pop_log.size();
    bpush = push_data.size();
    err0  = mon_err;
    load(1, 4, 30);
    wait_pops("t6", bpop, 1);
    cyc();
    check("t6_push_inflight", push, 1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_pop",      pop,      0);
    check("t6_rst_push",     push,     0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_grant",    grant_id, 0);
    check("t6_rst_busy",     busy,     0);
    load(0, 2, 60);
    repeat (2) cyc();
    reset = 1'b1;
    bpop  = pop_log.size();
    bpush = push_data.size();
    wait_quiet("t6", 80);
    exp_vc  = '{0, 0, 1, 1, 1};
    exp_dat = '{60, 61, 31, 32, 33};
    cmp_logs("t6", bpop, bpush);
    check("t6_monitor", mon_err - err0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
